ripple_ctr_sampler: RTL and testbench
=====================================

Name: ripple_ctr_sampler

Overview:
Consumer stage for the ripple counter. It brings the counter's asynchronous, skewed Width-bit output into the system clock domain through a synchronizer and accepts a value only after it has been stable for a cycle. It extends the short wrapping count into a wide accumulator by adding modulo deltas. It exposes a valid/ready snapshot port, so software or a downstream stage can read the accumulated count coherently.

Parameters:
Width, 4, width of the incoming ripple count (must match the upstream counter).
AccWidth, 16, accumulator and snapshot width; must be at least Width.
SyncStages, 2, number of synchronizer flops on cnt_i; must be at least 2.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
cnt_i  input  Width  asynchronous ripple count from upstream
clear_i  input  1  zero the accumulator; the baseline is retained
snap_req_i  input  1  single-cycle request to capture the accumulator
snap_ready_i  input  1  consumer ready for the snapshot
snap_valid_o  output  1  snapshot held and valid
snap_o  output  AccWidth  captured accumulator value
acc_o  output  AccWidth  live accumulator
stable_o  output  1  synchronized sample is stable this cycle
overrun_o  output  1  one-cycle pulse when snap_req_i is dropped

Behaviour:
- Reset: all sync flops, prev, base, acc_o, snap_o, snap_valid_o and overrun_o go to 0. primed goes to 0. The FSM goes to IDLE. Reset has priority over every other input.
- Sync chain: cnt_i passes through SyncStages flops. The last stage is s.
- prev register: prev <= s on every cycle.
- Stability: stable_o = (s == prev), combinational from registers.
- Accept condition: accept occurs when stable_o = 1 and either primed = 0 or s differs from base.
- First accept after reset (primed = 0): base <= s and primed <= 1. Nothing is added to the accumulator.
- Later accepts:
  - delta = (s - base) mod 2^Width, zero-extended to AccWidth.
  - acc_o <= (acc_o + delta) mod 2^AccWidth.
  - base <= s.
- Latency: a step on cnt_i that is then held constant is reflected in acc_o SyncStages+2 clock edges later (4 edges at the default).
- Aliasing limit: upstream must advance by at most 2^Width - 1 between accepts. Larger advances alias silently and are not detected.
- clear_i: acc_o <= 0 at the next edge. If an accept happens in the same cycle, clear wins and that cycle's delta is discarded. base is still updated.
- Snapshot FSM, state IDLE:
  - snap_valid_o = 0.
  - If snap_req_i = 1: snap_o <= the value acc_o takes at this edge (accept and clear applied). snap_valid_o <= 1. Move to HOLD.
- Snapshot FSM, state HOLD:
  - snap_valid_o = 1 and snap_o stays constant.
  - If snap_ready_i = 1: snap_valid_o <= 0 and move to IDLE.
  - Any snap_req_i seen in HOLD, including on the handshake cycle, is dropped. overrun_o = 1 for the next cycle only.
- snap_ready_i is ignored while in IDLE.
- Reset while in HOLD: the snapshot is lost and snap_valid_o is 0 from the next edge.

Test Plan:
- Prime with zero count: rst_i for 2 cycles with cnt_i = 0, then 10 cycles idle. Required: acc_o = 0, stable_o = 1, snap_valid_o = 0, overrun_o = 0 throughout.
- Step and latency: cnt_i goes 0 to 3 and holds (Width=4, SyncStages=2). Required: acc_o = 3 exactly 4 edges after the change. Then cnt_i goes 3 to 7: acc_o = 7.
- Wrap-around: base 14, then cnt_i = 1. Required: delta = 3, so acc_o increases by exactly 3.
- Glitch rejection: cnt_i toggles every cycle between 5 and 10 for 6 cycles, then settles at 10 (base 5). Required: stable_o = 0 during the toggling, no accept occurs, and the final acc_o increase is exactly 5.
- Snapshot handshake: acc_o = 9 and snap_req_i is pulsed. Required: snap_valid_o = 1 and snap_o = 9 the next cycle. While snap_ready_i = 0 for 3 cycles and acc_o changes to 12, snap_o holds at 9. After snap_ready_i = 1, snap_valid_o = 0 on the next edge. A second snap_req_i issued during HOLD produces a 1-cycle overrun_o pulse and no new capture.
- Clear collision and mid-operation reset:
  - clear_i is asserted in the same cycle as an accept of delta 2. Required: acc_o = 0 and base updated.
  - rst_i is asserted while in HOLD. Required: snap_valid_o = 0, acc_o = 0, and the first accept after reset only primes base.

Source files
------------

// File: rtl/ripple_ctr_sampler.sv
// ripple_ctr_sampler
// Consumer stage for an asynchronous ripple counter. The skewed count is
// synchronized into the clk_i domain. A value is accepted only after it has
// held for a full cycle. Modulo deltas between accepted values are summed
// into a wide accumulator. A valid/ready snapshot port gives downstream logic
// a coherent copy of that accumulator.

module ripple_ctr_sampler #(
  parameter int Width      = 4,
  parameter int AccWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    cnt_i,
  input  logic                clear_i,
  input  logic                snap_req_i,
  input  logic                snap_ready_i,
  output logic                snap_valid_o,
  output logic [AccWidth-1:0] snap_o,
  output logic [AccWidth-1:0] acc_o,
  output logic                stable_o,
  output logic                overrun_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [Width-1:0]    sync_q [SyncStages];
  logic [Width-1:0]    s;
  logic [Width-1:0]    prev;
  logic [Width-1:0]    base;
  logic                primed;
  logic                accept;
  logic [Width-1:0]    diff;
  logic [AccWidth-1:0] delta;
  logic [AccWidth-1:0] acc_next;
  logic [0:0]          state;

  assign s = sync_q[SyncStages-1];

  // Multi-flop synchronizer chain that brings the ripple count into clk_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= cnt_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // One-cycle history of the synchronized value, used to detect stability
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev <= '0;
    end else begin
      prev <= s;
    end
  end

  assign stable_o = (s == prev);
  assign accept   = stable_o && (!primed || (s != base));

  // Delta is taken modulo 2^Width so that counter wrap-around adds correctly
  always_comb begin
    diff     = s - base;
    delta    = AccWidth'(diff);
    acc_next = acc_o;
    if (clear_i) begin
      acc_next = '0;
    end else if (accept && primed) begin
      acc_next = acc_o + delta;
    end
  end

  // Baseline tracking and accumulation. The first accept only primes the baseline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base   <= '0;
      primed <= 1'b0;
      acc_o  <= '0;
    end else begin
      acc_o <= acc_next;
      if (accept) begin
        base   <= s;
        primed <= 1'b1;
      end
    end
  end

  // Snapshot handshake. The capture uses the post-edge accumulator value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      snap_o       <= '0;
      snap_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      case (state)
        IDLE: begin
          if (snap_req_i) begin
            snap_o       <= acc_next;
            snap_valid_o <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (snap_req_i) begin
            overrun_o <= 1'b1;
          end
          if (snap_ready_i) begin
            snap_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          snap_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_ctr_sampler.sv
// tb_ripple_ctr_sampler
// Directed self-checking bench for ripple_ctr_sampler at the default
// parameters (Width=4, AccWidth=16, SyncStages=2).

module tb_ripple_ctr_sampler;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  cnt_i;
  logic        clear_i;
  logic        snap_req_i;
  logic        snap_ready_i;
  logic        snap_valid_o;
  logic [15:0] snap_o;
  logic [15:0] acc_o;
  logic        stable_o;
  logic        overrun_o;

  int checks;
  int errors;

  ripple_ctr_sampler #(
    .Width(4),
    .AccWidth(16),
    .SyncStages(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cnt_i(cnt_i),
    .clear_i(clear_i),
    .snap_req_i(snap_req_i),
    .snap_ready_i(snap_ready_i),
    .snap_valid_o(snap_valid_o),
    .snap_o(snap_o),
    .acc_o(acc_o),
    .stable_o(stable_o),
    .overrun_o(overrun_o)
  );

  // Free-running 10 ns system clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs are changed and outputs read 1 ns after it
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_i        = 1'b1;
    cnt_i        = 4'd0;
    clear_i      = 1'b0;
    snap_req_i   = 1'b0;
    snap_ready_i = 1'b0;

    // Reset and prime with a zero count
    applyStimulus(2);
    checkOutput("rst_acc", 32'(acc_o), 32'd0);
    checkOutput("rst_valid", 32'(snap_valid_o), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_o), 32'd0);
    checkOutput("rst_snap", 32'(snap_o), 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("idle_acc", 32'(acc_o), 32'd0);
      checkOutput("idle_stable", 32'(stable_o), 32'd1);
      checkOutput("idle_valid", 32'(snap_valid_o), 32'd0);
      checkOutput("idle_overrun", 32'(overrun_o), 32'd0);
    end

    // Step 0 -> 3: visible exactly four edges later
    cnt_i = 4'd3;
    applyStimulus(1);
    checkOutput("step_e1_acc", 32'(acc_o), 32'd0);
    applyStimulus(1);
    checkOutput("step_e2_stable", 32'(stable_o), 32'd0);
    applyStimulus(1);
    checkOutput("step_e3_acc", 32'(acc_o), 32'd0);
    checkOutput("step_e3_stable", 32'(stable_o), 32'd1);
    applyStimulus(1);
    checkOutput("step_e4_acc", 32'(acc_o), 32'd3);
    applyStimulus(2);
    checkOutput("step_hold_acc", 32'(acc_o), 32'd3);

    // Step 3 -> 7
    cnt_i = 4'd7;
    applyStimulus(4);
    checkOutput("step7_acc", 32'(acc_o), 32'd7);

    // Raise base to 14, then wrap to 1: delta 3
    cnt_i = 4'd14;
    applyStimulus(5);
    checkOutput("base14_acc", 32'(acc_o), 32'd14);
    cnt_i = 4'd1;
    applyStimulus(5);
    checkOutput("wrap_acc", 32'(acc_o), 32'd17);

    // Base 5 (delta 4 -> 21)
    cnt_i = 4'd5;
    applyStimulus(5);
    checkOutput("base5_acc", 32'(acc_o), 32'd21);

    // Glitch: toggle 10/5 for six cycles, then settle on 10
    for (int i = 0; i < 6; i++) begin
      cnt_i = (i % 2 == 0) ? 4'd10 : 4'd5;
      applyStimulus(1);
      if (i >= 1) begin
        checkOutput("glitch_stable", 32'(stable_o), 32'd0);
      end
      checkOutput("glitch_acc", 32'(acc_o), 32'd21);
    end
    cnt_i = 4'd10;
    applyStimulus(2);
    checkOutput("glitch_tail_stable", 32'(stable_o), 32'd0);
    checkOutput("glitch_tail_acc", 32'(acc_o), 32'd21);
    applyStimulus(1);
    checkOutput("glitch_settle_stable", 32'(stable_o), 32'd1);
    checkOutput("glitch_settle_acc", 32'(acc_o), 32'd21);
    applyStimulus(1);
    checkOutput("glitch_final_acc", 32'(acc_o), 32'd26);

    // Plain clear, then 10 -> 3 (delta 9) for acc = 9
    clear_i = 1'b1;
    applyStimulus(1);
    clear_i = 1'b0;
    checkOutput("clear_acc", 32'(acc_o), 32'd0);
    cnt_i = 4'd3;
    applyStimulus(5);
    checkOutput("pre_snap_acc", 32'(acc_o), 32'd9);

    // Snapshot capture and hold while not ready
    snap_req_i = 1'b1;
    applyStimulus(1);
    snap_req_i = 1'b0;
    checkOutput("snap_valid", 32'(snap_valid_o), 32'd1);
    checkOutput("snap_value", 32'(snap_o), 32'd9);
    cnt_i = 4'd6;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("hold_valid", 32'(snap_valid_o), 32'd1);
      checkOutput("hold_value", 32'(snap_o), 32'd9);
    end
    checkOutput("hold_acc", 32'(acc_o), 32'd12);

    // Second request in HOLD: overrun pulse, no new capture
    snap_req_i = 1'b1;
    applyStimulus(1);
    snap_req_i = 1'b0;
    checkOutput("overrun_pulse", 32'(overrun_o), 32'd1);
    checkOutput("overrun_value", 32'(snap_o), 32'd9);
    applyStimulus(1);
    checkOutput("overrun_clear", 32'(overrun_o), 32'd0);
    checkOutput("overrun_valid", 32'(snap_valid_o), 32'd1);

    // Handshake completes
    snap_ready_i = 1'b1;
    applyStimulus(1);
    snap_ready_i = 1'b0;
    checkOutput("ready_valid", 32'(snap_valid_o), 32'd0);

    // Clear colliding with an accept of delta 2 (6 -> 8)
    cnt_i = 4'd8;
    applyStimulus(3);
    checkOutput("collide_pre_acc", 32'(acc_o), 32'd12);
    clear_i = 1'b1;
    applyStimulus(1);
    clear_i = 1'b0;
    checkOutput("collide_acc", 32'(acc_o), 32'd0);
    cnt_i = 4'd9;
    applyStimulus(5);
    checkOutput("collide_base_acc", 32'(acc_o), 32'd1);

    // Request plus clear in the same cycle captures the cleared value
    snap_req_i = 1'b1;
    clear_i    = 1'b1;
    applyStimulus(1);
    snap_req_i = 1'b0;
    clear_i    = 1'b0;
    checkOutput("snapclr_valid", 32'(snap_valid_o), 32'd1);
    checkOutput("snapclr_value", 32'(snap_o), 32'd0);

    // Build acc back up to 4 while still in HOLD, then reset mid-HOLD
    cnt_i = 4'd13;
    applyStimulus(5);
    checkOutput("prereset_acc", 32'(acc_o), 32'd4);
    checkOutput("prereset_valid", 32'(snap_valid_o), 32'd1);
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
    checkOutput("hold_rst_valid", 32'(snap_valid_o), 32'd0);
    checkOutput("hold_rst_acc", 32'(acc_o), 32'd0);
    checkOutput("hold_rst_snap", 32'(snap_o), 32'd0);
    // First accept after reset primes base with the zeroed sync value only;
    // the held count 13 then arrives as a normal delta four edges later.
    applyStimulus(1);
    checkOutput("reprime_e1_acc", 32'(acc_o), 32'd0);
    applyStimulus(2);
    checkOutput("reprime_e3_acc", 32'(acc_o), 32'd0);
    applyStimulus(1);
    checkOutput("reprime_e4_acc", 32'(acc_o), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
